fb_access_arbiter: RTL and testbench
====================================

// Module: fb_access_arbiter
// PURPOSE
//  Sequences and shares one single-port 640x480x12 frame-buffer BRAM between the camera
//  capture path (writer) and the VGA scan-out path (reader), all on a single clock.
//  Generates frame-relative write/read addresses with wrap and per-frame reset.
//  Buffers writes in a small FIFO so that VGA reads, which have priority, never drop pixels.
//  Sits between the capture FSM / VGA timing generator and the BRAM instance.
// PARAMETERS
//  FRAME_PIXELS  307200  pixels per frame; address range 0..FRAME_PIXELS-1
//  ADDR_W        19      BRAM address width
//  DATA_W        12      pixel width (RGB444)
//  WFIFO_DEPTH   4       write FIFO entries (power of 2, >=2); each entry holds {addr,data}
// PORTS
//  clk           in   1       system clock
//  rst_n         in   1       asynchronous active-low reset
//  cam_vsync     in   1       1-cycle pulse: the next accepted pixel is frame address 0
//  cam_valid     in   1       camera pixel valid
//  cam_data      in   DATA_W  camera pixel
//  vga_vsync     in   1       1-cycle pulse: the next read request is frame address 0
//  vga_req       in   1       request for the next sequential pixel
//  vga_rd_valid  out  1       vga_rd_data is valid this cycle
//  vga_rd_data   out  DATA_W  read pixel (equals bram_rdata while vga_rd_valid is high)
//  bram_en       out  1       BRAM enable (registered)
//  bram_we       out  1       BRAM write enable (registered)
//  bram_addr     out  ADDR_W  BRAM address (registered)
//  bram_wdata    out  DATA_W  BRAM write data (registered)
//  bram_rdata    in   DATA_W  BRAM read data; 1-cycle latency after bram_en with !bram_we
//  wr_overflow   out  1       sticky: a camera pixel was dropped
//  rd_overrun    out  1       sticky: a VGA request was dropped
//  fifo_level    out  3       write FIFO occupancy, 0..WFIFO_DEPTH (width = clog2(DEPTH)+1)
// BEHAVIOUR
//  Reset (async): all outputs 0; wr_addr, rd_addr, FIFO pointers, and pending read cleared.
//  Write address: each pixel pushed into the FIFO is tagged with wr_addr, then
//   wr_addr <= (wr_addr==FRAME_PIXELS-1) ? 0 : wr_addr+1. When cam_vsync is high, the
//   counter is set to 0; if cam_valid is in the same cycle, that pixel is tagged 0.
//  Read address: same rules using rd_addr, vga_req, and vga_vsync. rd_addr advances on each
//   accepted request, including a request that becomes pending.
//  Arbitration, evaluated each cycle in this order; the grant is registered onto the bram_* ports:
//   1. Pending read set -> grant the read, clear pending.
//   2. FIFO full -> grant the write (pop). A concurrent vga_req sets pending.
//   3. vga_req -> grant the read.
//   4. FIFO not empty -> grant the write (pop).
//   5. Otherwise bram_en=0.
//  vga_req while pending is set and no read is granted -> request dropped, rd_overrun<=1,
//   rd_addr not advanced.
//  FIFO push with pop in the same cycle is allowed at any level. A push when full and no pop
//   -> pixel dropped, wr_overflow<=1, wr_addr not advanced.
//  Read latency: vga_req at cycle N -> bram_en at N+1 -> vga_rd_valid at N+2. If the read is
//   deferred (case 2), vga_rd_valid is at N+3. Reads return in request order.
//  Write latency: a pixel pushed at cycle N with the FIFO empty and no read -> bram_we at N+1.
//  Sticky flags clear only on reset. No read-after-write hazard checking: the frame is tearing-tolerant.
// TESTING
//  1. Write-only: 8 pixels 0x001..0x008 after cam_vsync -> bram_we with addr 0..7 and matching
//     data, one per cycle, first at +1 cycle.
//  2. Read-only: vga_vsync, then 4 back-to-back vga_req -> bram addr 0..3;
//     vga_rd_valid at req+2 each.
//  3. Contention: cam_valid and vga_req every cycle for 20 cycles -> FIFO fills; reads are
//     deferred by at most 1 cycle; wr_overflow=1 at the first full push with no pop;
//     rd_overrun stays 0.
//  4. Wrap: preload wr_addr by pushing 307199 pixels; the next pixel -> addr 307199,
//     the one after -> addr 0.
//  5. vsync mid-frame: cam_vsync at wr_addr=1000 together with cam_valid -> that pixel is
//     written to addr 0; queued older entries keep their addresses 998 and 999.
//  6. Async reset asserted mid-burst -> all outputs 0 immediately; after release, the first
//     write goes to addr 0 and the flags are 0.

Source files
------------

// File: rtl/fb_access_arbiter.sv
// Shares one single-port frame-buffer BRAM between the camera writer and the VGA reader.
// VGA reads have priority; camera pixels are buffered in a small {addr,data} FIFO.
module fb_access_arbiter #(
    parameter int unsigned FRAME_PIXELS = 307200,
    parameter int unsigned ADDR_W       = 19,
    parameter int unsigned DATA_W       = 12,
    parameter int unsigned WFIFO_DEPTH  = 4,
    localparam int unsigned PTR_W       = $clog2(WFIFO_DEPTH),
    localparam int unsigned LVL_W       = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cam_vsync,
    input  logic              cam_valid,
    input  logic [DATA_W-1:0] cam_data,
    input  logic              vga_vsync,
    input  logic              vga_req,
    output logic              vga_rd_valid,
    output logic [DATA_W-1:0] vga_rd_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_wdata,
    input  logic [DATA_W-1:0] bram_rdata,
    output logic              wr_overflow,
    output logic              rd_overrun,
    output logic [LVL_W-1:0]  fifo_level
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(WFIFO_DEPTH);

    logic [ADDR_W+DATA_W-1:0] mem_q [WFIFO_DEPTH];
    logic [PTR_W-1:0]         wptr_q, rptr_q;
    logic [LVL_W-1:0]         level_q;
    logic [ADDR_W-1:0]        wr_addr_q, rd_addr_q, pend_addr_q;
    logic                     pend_q;

    logic                     fifo_empty, fifo_full;
    logic [ADDR_W-1:0]        wr_tag, rd_tag, rd_sel_addr, pend_addr_d;
    logic                     grant_rd, grant_wr, pend_d, rd_accept;
    logic                     pop, bypass, push_ok, store, deq;
    logic [ADDR_W+DATA_W-1:0] head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FULL_LVL);
    assign wr_tag     = cam_vsync ? '0 : wr_addr_q;
    assign rd_tag     = vga_vsync ? '0 : rd_addr_q;

    always_comb begin
        grant_rd    = 1'b0;
        grant_wr    = 1'b0;
        rd_sel_addr = rd_tag;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        rd_accept   = 1'b0;
        if (pend_q) begin
            // Serving the deferred read; a new request takes its place in the pending slot.
            grant_rd    = 1'b1;
            rd_sel_addr = pend_addr_q;
            pend_d      = vga_req;
            pend_addr_d = rd_tag;
            rd_accept   = vga_req;
        end else if (fifo_full) begin
            grant_wr = 1'b1;
            if (vga_req) begin
                pend_d      = 1'b1;
                pend_addr_d = rd_tag;
                rd_accept   = 1'b1;
            end
        end else if (vga_req) begin
            grant_rd  = 1'b1;
            rd_accept = 1'b1;
        end else if (!fifo_empty || cam_valid) begin
            grant_wr = 1'b1;
        end
    end

    // An empty FIFO forwards the incoming pixel straight to the BRAM port.
    assign pop     = grant_wr;
    assign bypass  = pop && fifo_empty;
    assign push_ok = cam_valid && (!fifo_full || pop);
    assign store   = push_ok && !bypass;
    assign deq     = pop && !bypass;
    assign head    = bypass ? {wr_tag, cam_data} : mem_q[rptr_q];

    assign fifo_level  = level_q;
    assign vga_rd_data = vga_rd_valid ? bram_rdata : '0;

    always_ff @(posedge clk) begin
        if (store) mem_q[wptr_q] <= {wr_tag, cam_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            level_q      <= '0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            pend_q       <= 1'b0;
            pend_addr_q  <= '0;
            bram_en      <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_wdata   <= '0;
            vga_rd_valid <= 1'b0;
            wr_overflow  <= 1'b0;
            rd_overrun   <= 1'b0;
        end else begin
            if (store) wptr_q <= wptr_q + 1'b1;
            if (deq)   rptr_q <= rptr_q + 1'b1;
            level_q <= level_q + LVL_W'(store) - LVL_W'(deq);

            if (push_ok)        wr_addr_q <= (wr_tag == LAST_ADDR) ? '0 : wr_tag + 1'b1;
            else if (cam_vsync) wr_addr_q <= '0;
            if (rd_accept)      rd_addr_q <= (rd_tag == LAST_ADDR) ? '0 : rd_tag + 1'b1;
            else if (vga_vsync) rd_addr_q <= '0;

            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;

            bram_en    <= grant_rd || grant_wr;
            bram_we    <= grant_wr;
            bram_addr  <= grant_wr ? head[ADDR_W+DATA_W-1:DATA_W] : rd_sel_addr;
            bram_wdata <= grant_wr ? head[DATA_W-1:0] : '0;

            vga_rd_valid <= bram_en && !bram_we;

            if (cam_valid && !push_ok) wr_overflow <= 1'b1;
            if (vga_req && !rd_accept) rd_overrun  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// Directed bench for fb_access_arbiter with a behavioural 1-cycle-latency BRAM.
// Frame size is reduced so address wrap is reachable in a short run.
module tb_fb_access_arbiter;

    localparam int unsigned FRAME  = 1200;
    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 12;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              cam_vsync, cam_valid, vga_vsync, vga_req;
    logic [DATA_W-1:0] cam_data;
    logic              vga_rd_valid, bram_en, bram_we, wr_overflow, rd_overrun;
    logic [DATA_W-1:0] vga_rd_data, bram_wdata, bram_rdata;
    logic [ADDR_W-1:0] bram_addr;
    logic [2:0]        fifo_level;

    logic [DATA_W-1:0] bram_mem [2048];
    int                n_pass = 0;
    int                n_total = 0;
    int                rd_seen;

    fb_access_arbiter #(
        .FRAME_PIXELS(FRAME),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .WFIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cam_vsync   (cam_vsync),
        .cam_valid   (cam_valid),
        .cam_data    (cam_data),
        .vga_vsync   (vga_vsync),
        .vga_req     (vga_req),
        .vga_rd_valid(vga_rd_valid),
        .vga_rd_data (vga_rd_data),
        .bram_en     (bram_en),
        .bram_we     (bram_we),
        .bram_addr   (bram_addr),
        .bram_wdata  (bram_wdata),
        .bram_rdata  (bram_rdata),
        .wr_overflow (wr_overflow),
        .rd_overrun  (rd_overrun),
        .fifo_level  (fifo_level)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        if (bram_en && bram_we) bram_mem[bram_addr[10:0]] <= bram_wdata;
        if (bram_en && !bram_we) bram_rdata <= bram_mem[bram_addr[10:0]];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cam_vsync = 1'b0;
        cam_valid = 1'b0;
        vga_vsync = 1'b0;
        vga_req   = 1'b0;
    endtask

    // {en, we, addr, wdata} packed for compact port checks
    function automatic logic [63:0] bus(input logic en, input logic we, input int addr,
                                        input int data);
        return {31'd0, en, we, addr[ADDR_W-1:0], data[DATA_W-1:0]};
    endfunction

    function automatic logic [63:0] bus_now();
        return {31'd0, bram_en, bram_we, bram_addr, bram_wdata};
    endfunction

    function automatic logic [63:0] rd_bus_now();
        return {31'd0, bram_en, bram_we, bram_addr, {DATA_W{1'b0}}};
    endfunction

    initial begin
        rst_n    = 1'b0;
        cam_data = '0;
        idle();
        #12;
        chk("rst_bram", bus_now(), 64'd0);
        chk("rst_rd", {vga_rd_valid, vga_rd_data}, 64'd0);
        chk("rst_flags", {wr_overflow, rd_overrun, fifo_level}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Write-only burst
        cam_vsync = 1'b1;
        step();
        cam_vsync = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cam_valid = 1'b1;
            cam_data  = DATA_W'(i + 1);
            step();
            chk($sformatf("t1_wr%0d", i), bus_now(), bus(1'b1, 1'b1, i, i + 1));
        end
        idle();
        step();
        chk("t1_idle", {63'd0, bram_en}, 64'd0);

        // Read-only burst
        vga_vsync = 1'b1;
        step();
        vga_vsync = 1'b0;
        for (int k = 0; k < 6; k++) begin
            vga_req = (k < 4);
            step();
            if (k < 4) chk($sformatf("t2_rd%0d", k), rd_bus_now(), bus(1'b1, 1'b0, k, 0));
            if (k >= 1 && k <= 4)
                chk($sformatf("t2_data%0d", k), {vga_rd_valid, vga_rd_data}, {51'd1, 12'(k)});
            if (k == 5) chk("t2_done", {63'd0, vga_rd_valid}, 64'd0);
        end

        // Contention: reads win, FIFO fills, one deferral, then overflow
        rd_seen = 0;
        for (int k = 0; k < 20; k++) begin
            cam_vsync = (k == 0);
            vga_vsync = (k == 0);
            cam_valid = 1'b1;
            vga_req   = 1'b1;
            cam_data  = DATA_W'(12'h100 + k);
            step();
            rd_seen += int'(vga_rd_valid);
            if (k == 3) chk("t3_full", {61'd0, fifo_level}, 64'd4);
            if (k == 4) begin
                chk("t3_forced_wr", bus_now(), bus(1'b1, 1'b1, 0, 12'h100));
                chk("t3_no_ovf_yet", {63'd0, wr_overflow}, 64'd0);
            end
            if (k == 5) begin
                chk("t3_deferred_rd", rd_bus_now(), bus(1'b1, 1'b0, 4, 0));
                chk("t3_ovf", {63'd0, wr_overflow}, 64'd1);
                chk("t3_gap", {63'd0, vga_rd_valid}, 64'd0);
            end
            if (k == 6) chk("t3_deferred_valid", {63'd0, vga_rd_valid}, 64'd1);
            if (k == 12) chk("t3_rd_chain", rd_bus_now(), bus(1'b1, 1'b0, 11, 0));
        end
        idle();
        for (int d = 0; d < 8; d++) begin
            step();
            rd_seen += int'(vga_rd_valid);
            if (d == 1) chk("t3_drain_wr", bus_now(), bus(1'b1, 1'b1, 1, 12'h101));
        end
        chk("t3_reads", 64'(rd_seen), 64'd20);
        chk("t3_overrun", {63'd0, rd_overrun}, 64'd0);
        chk("t3_empty", {61'd0, fifo_level}, 64'd0);

        // Address wrap
        cam_vsync = 1'b1;
        step();
        cam_vsync = 1'b0;
        cam_valid = 1'b1;
        for (int i = 0; i < FRAME - 1; i++) begin
            cam_data = DATA_W'(i);
            step();
        end
        cam_data = 12'hABC;
        step();
        chk("t4_last", bus_now(), bus(1'b1, 1'b1, FRAME - 1, 12'hABC));
        cam_data = 12'hDEF;
        step();
        chk("t4_wrap", bus_now(), bus(1'b1, 1'b1, 0, 12'hDEF));
        idle();
        step();

        // vsync mid-frame with older entries queued behind reads
        cam_vsync = 1'b1;
        step();
        cam_vsync = 1'b0;
        cam_valid = 1'b1;
        for (int i = 0; i < 998; i++) begin
            cam_data = DATA_W'(i);
            step();
        end
        vga_req  = 1'b1;
        cam_data = 12'hA01;
        step();
        chk("t5_lvl1", {61'd0, fifo_level}, 64'd1);
        cam_data = 12'hA02;
        step();
        cam_vsync = 1'b1;
        cam_data  = 12'hA03;
        step();
        chk("t5_lvl3", {61'd0, fifo_level}, 64'd3);
        idle();
        step();
        chk("t5_q998", bus_now(), bus(1'b1, 1'b1, 998, 12'hA01));
        step();
        chk("t5_q999", bus_now(), bus(1'b1, 1'b1, 999, 12'hA02));
        step();
        chk("t5_vsync0", bus_now(), bus(1'b1, 1'b1, 0, 12'hA03));
        step();
        chk("t5_empty", {61'd0, fifo_level}, 64'd0);

        // Async reset mid-burst
        chk("t6_ovf_before", {63'd0, wr_overflow}, 64'd1);
        cam_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cam_data = DATA_W'(12'h300 + i);
            step();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_bram", bus_now(), 64'd0);
        chk("t6_rst_misc", {vga_rd_valid, vga_rd_data, wr_overflow, rd_overrun, fifo_level},
            64'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        cam_data = 12'h5A5;
        step();
        chk("t6_first_wr", bus_now(), bus(1'b1, 1'b1, 0, 12'h5A5));
        chk("t6_flags", {62'd0, wr_overflow, rd_overrun}, 64'd0);
        idle();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
